phase_error_detector: RTL
=========================

// Module: phase_error_detector
// PURPOSE
//  Companion to variable_sampler on the receive path. Consumes the sampler's
//  enb strobe and the serial rxd line. Measures where data edges land within
//  the SAMPLE_FREQ-slot bit window. Issues one-cycle speed_up/slow_down pulses
//  with a diff_amt magnitude, closing the sampler's clock-recovery loop.
// PARAMETERS
//  SAMPLE_FREQ  16  enb strobes per bit; power of 2, >=4
//  DEADBAND     1   edge errors with |e| <= DEADBAND produce no correction
//  MAX_DIFF     5   diff_amt clip ceiling; 1..5, the range the sampler scales
//  HOLDOFF      16  enb strobes during which edges are ignored after a correction
// PORTS
//  clk        in   1  system clock
//  reset      in   1  asynchronous, active-low reset
//  enb        in   1  sample strobe from variable_sampler, 1 clk wide
//  rxd        in   1  serial data, asynchronous to clk
//  active     in   1  tracking enable; high while a frame is being received
//  speed_up   out  1  1-clk pulse: edge early, sampler must run faster
//  slow_down  out  1  1-clk pulse: edge late, sampler must run slower
//  diff_amt   out  5  correction magnitude 1..MAX_DIFF; valid with pulse, held after
//  edge_phase out  PW phase slot of the last detected edge (debug); PW=$clog2(SAMPLE_FREQ)
// BEHAVIOUR
//  - Reset (reset=0, async): all outputs 0; phase=0, holdoff cnt=0.
//    last_sample=1 (idle line); sync flops=1. Takes effect mid-operation at once.
//  - rxd passes a 2-flop synchronizer on clk; rxd_s is the synchronized value.
//  - phase: PW-bit counter, +1 mod SAMPLE_FREQ on every enb while active=1.
//  - On an enb cycle, edge = (rxd_s != last_sample); then last_sample <= rxd_s.
//  - p = phase value before this enb's increment. On edge with active=1 and
//    holdoff=0:
//      p==0                 -> e=0, no correction
//      1 <= p < SF/2        -> late by p: slow_down, |e|=p
//      SF/2 <= p <= SF-1    -> early by SF-p: speed_up, |e|=SF-p
//    Also edge_phase <= p.
//  - If |e| > DEADBAND:
//    - Pulse asserts in the clk cycle right after the enb cycle: latency 1 clk,
//      width exactly 1 clk. Never both pulses at once.
//    - diff_amt <= min(|e|, MAX_DIFF), registered with the pulse and held until
//      the next correction.
//    - holdoff <= HOLDOFF.
//  - holdoff decrements on each enb while nonzero. Edges seen while holdoff != 0
//    update last_sample only.
//  - Pulses are one clk wide because the sampler accepts one correction per
//    !changed cycle. A held level would be accumulated repeatedly.
//  - active=0:
//    - phase and holdoff are forced to 0; no pulses.
//    - last_sample still tracks rxd_s on enb.
//    - active falling in the same cycle as a qualifying edge: active wins.
//  - Back-to-back enb on consecutive clks is supported. A pending pulse from
//    the prior cycle still issues.
//  - Arithmetic is unsigned PW-bit; SF-p is computed at PW+1 bits, no wrap.
// CONFIGURATION
//  PHASE_REALIGN_EN defined:
//    - On any detected edge (active=1, holdoff ignored), phase reloads to 1
//      instead of p+1. The edge slot becomes slot 0 and the bit grid snaps to
//      the data.
//    - Corrections are still issued as above.
//  PHASE_REALIGN_EN undefined:
//    - phase free-runs mod SAMPLE_FREQ.
//    - Alignment relies solely on sampler rate corrections.
// TESTING
//  1 reset=0 mid-frame with pending pulse -> speed_up=slow_down=0, diff_amt=0
//    same cycle, edge_phase=0.
//  2 SF=16, edge at p=3 -> slow_down high 1 clk after enb, diff_amt=3,
//    edge_phase=3, speed_up stays 0.
//  3 edge at p=13 -> speed_up 1-clk pulse, diff_amt=3.
//    Edge at p=8 -> speed_up, diff_amt=5 (clipped).
//  4 edge at p=1 and p=15 (DEADBAND=1) -> no pulse, diff_amt unchanged,
//    edge_phase updates.
//  5 correction at p=4, second edge 10 enb later -> second ignored.
//    Edge 17 enb later -> pulse issued.
//  6 PHASE_REALIGN_EN, edge at p=5 -> phase=1 after that enb, slow_down diff=5.
//    Undefined: phase=6. active=0 -> no pulses, phase=0.

Source files
------------

// File: rtl/phase_error_detector.sv
// Phase error detector: locates data edges within the SAMPLE_FREQ-slot bit window
// and issues one-clk speed_up/slow_down corrections. Optional macro: PHASE_REALIGN_EN.
module phase_error_detector #(
    parameter int SAMPLE_FREQ = 16,
    parameter int DEADBAND    = 1,
    parameter int MAX_DIFF    = 5,
    parameter int HOLDOFF     = 16,
    localparam int PW         = $clog2(SAMPLE_FREQ)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enb,
    input  logic          rxd,
    input  logic          active,
    output logic          speed_up,
    output logic          slow_down,
    output logic [4:0]    diff_amt,
    output logic [PW-1:0] edge_phase
);

    localparam int PW1 = PW + 1;
    localparam int HW  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    localparam logic [PW:0]   SF_W   = PW1'(SAMPLE_FREQ);
    localparam logic [PW:0]   HALF_W = SF_W >> 1;
    localparam logic [PW:0]   DB_W   = PW1'(DEADBAND);
    localparam logic [PW:0]   MAX_W  = PW1'(MAX_DIFF);
    localparam logic [HW-1:0] HOLD_W = HW'(HOLDOFF);

    logic          rxd_m;
    logic          rxd_s;
    logic          last_sample;
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_step;
    logic [HW-1:0] holdoff_cnt;
    logic [PW:0]   p_w;
    logic [PW:0]   err_mag;
    logic [4:0]    diff_next;
    logic          late;
    logic          edge_det;
    logic          track;
    logic          correct;

    // Two-flop synchronizer; reset to the idle (mark) level so no false edge at start.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    assign edge_det = enb && (rxd_s != last_sample);
    assign track    = edge_det && active && (holdoff_cnt == '0);
    assign p_w      = {1'b0, phase};

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        late    = 1'b0;
        err_mag = '0;
        if (p_w == '0) begin
            err_mag = '0;
        end else if (p_w < HALF_W) begin
            late    = 1'b1;
            err_mag = p_w;
        end else begin
            err_mag = SF_W - p_w;
        end
    end

    assign correct   = track && (err_mag > DB_W);
    assign diff_next = (err_mag > MAX_W) ? 5'(MAX_W) : 5'(err_mag);

`ifdef PHASE_REALIGN_EN
    // The edge slot becomes slot 0, so the next slot is 1 regardless of holdoff.
    assign phase_step = edge_det ? PW'(1) : phase + PW'(1);
`else
    assign phase_step = phase + PW'(1);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_sample <= 1'b1;
            phase       <= '0;
            holdoff_cnt <= '0;
            speed_up    <= 1'b0;
            slow_down   <= 1'b0;
            diff_amt    <= '0;
            edge_phase  <= '0;
        end else begin
            speed_up  <= 1'b0;
            slow_down <= 1'b0;

            if (enb) begin
                last_sample <= rxd_s;
            end

            if (!active) begin
                phase       <= '0;
                holdoff_cnt <= '0;
            end else if (enb) begin
                phase <= phase_step;

                if (correct) begin
                    holdoff_cnt <= HOLD_W;
                end else if (holdoff_cnt != '0) begin
                    holdoff_cnt <= holdoff_cnt - HW'(1);
                end

                if (track) begin
                    edge_phase <= phase;
                end

                // Single-cycle pulse: the sampler would re-apply a held level.
                if (correct) begin
                    speed_up  <= !late;
                    slow_down <= late;
                    diff_amt  <= diff_next;
                end
            end
        end
    end

endmodule
